// File: rtl/tetromino_bag_queue_pkg.sv
// GamePkg: shared types, constants and helper functions for the tetromino
// bag queue (tile encoding, LFSR constants, 7-bag selection helpers).
package GamePkg;

    localparam int unsigned PIECE_W    = 3;
    localparam int unsigned LFSR_W     = 16;
    localparam int unsigned BAG_W      = 7;

    typedef enum logic [PIECE_W-1:0] {
        PIECE_I    = 3'd0,
        PIECE_O    = 3'd1,
        PIECE_T    = 3'd2,
        PIECE_S    = 3'd3,
        PIECE_Z    = 3'd4,
        PIECE_J    = 3'd5,
        PIECE_L    = 3'd6,
        PIECE_NONE = 3'd7
    } tile_type_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_READY = 2'd2
    } queue_state_t;

    localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;
    localparam logic [LFSR_W-1:0] LFSR_TAPS         = 16'hB400;
    localparam logic [BAG_W-1:0]  BAG_FULL          = 7'h7F;

    // One Galois step, shifting right; taps applied when bit 0 falls out.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : '0);
    endfunction

    // Number of pieces still available in the bag (1..7 in normal use).
    function automatic logic [PIECE_W-1:0] bag_count(input logic [BAG_W-1:0] bag);
        logic [PIECE_W-1:0] n;
        n = '0;
        for (int i = 0; i < BAG_W; i++) begin
            n = n + PIECE_W'(bag[i]);
        end
        return n;
    endfunction

    // Index of the k-th set bit of the bag, counting from bit 0.
    function automatic logic [PIECE_W-1:0] bag_pick(input logic [BAG_W-1:0]   bag,
                                                    input logic [PIECE_W-1:0] k);
        logic [PIECE_W-1:0] seen;
        logic [PIECE_W-1:0] pick;
        logic               found;
        seen  = '0;
        pick  = PIECE_W'(PIECE_NONE);
        found = 1'b0;
        for (int i = 0; i < BAG_W; i++) begin
            if (bag[i] && !found) begin
                if (seen == k) begin
                    pick  = PIECE_W'(i);
                    found = 1'b1;
                end
                seen = seen + 3'd1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/tetromino_bag_queue_lfsr16.sv
// lfsr16: 16-bit Galois LFSR used as the bag randomiser.
// Ports: clk, rst (async, active-high), load (takes seed; zero seed maps to
// the default seed), step (advance one state), seed, value (current state).
module lfsr16
    import GamePkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              step,
    output logic [LFSR_W-1:0] value
);

    // An all-zero state would lock the LFSR, so a zero seed is replaced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= LFSR_DEFAULT_SEED;
        end else if (load) begin
            value <= (seed == '0) ? LFSR_DEFAULT_SEED : seed;
        end else if (step) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/tetromino_bag_queue.sv
// tetromino_bag_queue: 7-bag randomised piece queue with preview and an
// optional hold slot.
// Ports: clk, rst (async, active-high), game_start/game_end (pulses),
// seed (sampled on game_start), new_tetromino (pop), hold_req (hold/swap),
// current_piece, preview (entry 0 in [2:0] is next), queue_valid (READY),
// hold_piece.
// Build option: define TETROMINO_HOLD_EN to include the hold slot; without
// it hold_req is ignored and hold_piece is constant PIECE_NONE.
module tetromino_bag_queue
    import GamePkg::*;
#(
    parameter int unsigned PREVIEW_DEPTH = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         game_start,
    input  logic                         game_end,
    input  logic [LFSR_W-1:0]            seed,
    input  logic                         new_tetromino,
    input  logic                         hold_req,
    output tile_type_t                   current_piece,
    output logic [PIECE_W*PREVIEW_DEPTH-1:0] preview,
    output logic                         queue_valid,
    output tile_type_t                   hold_piece
);

    localparam int unsigned QLEN  = PREVIEW_DEPTH + 1;
    localparam int unsigned CNT_W = 3;

    queue_state_t         state;
    logic [PIECE_W-1:0]   q [QLEN];
    logic [BAG_W-1:0]     bag;
    logic [CNT_W-1:0]     fill_cnt;
    logic                 pending;

    logic [LFSR_W-1:0]    lfsr_value;
    logic [7:0]           gen_byte;
    logic [PIECE_W-1:0]   gen_k;
    logic [PIECE_W-1:0]   gen_piece;
    logic [BAG_W-1:0]     bag_left;
    logic [BAG_W-1:0]     gen_bag;

    logic                 fill_en;
    logic                 pop_en;
    logic                 gen_en;
    logic                 load_en;

`ifdef TETROMINO_HOLD_EN
    logic [PIECE_W-1:0]   hold_q;
    logic                 hold_used;
    logic                 hold_take;
    logic                 hold_swap;
`else
    logic                 unused_hold_req;
    assign unused_hold_req = hold_req;
`endif

    // Next piece is drawn from the LFSR state after this cycle's step.
    assign gen_byte  = 8'(lfsr_next(lfsr_value));
    assign gen_k     = PIECE_W'(gen_byte % {5'd0, bag_count(bag)});
    assign gen_piece = bag_pick(bag, gen_k);
    assign bag_left  = bag & ~(BAG_W'(1) << gen_piece);
    assign gen_bag   = (bag_left == '0) ? BAG_FULL : bag_left;

    // Per-cycle action decode; game_end and game_start override everything.
    always_comb begin
        fill_en = 1'b0;
        pop_en  = 1'b0;
`ifdef TETROMINO_HOLD_EN
        hold_take = 1'b0;
        hold_swap = 1'b0;
`endif
        if (!game_end && !game_start) begin
            if (state == ST_FILL) begin
                fill_en = 1'b1;
            end else if (state == ST_READY) begin
                if (new_tetromino || pending) begin
                    pop_en = 1'b1;
                end
`ifdef TETROMINO_HOLD_EN
                else if (hold_req && !hold_used) begin
                    if (hold_q == PIECE_W'(PIECE_NONE)) begin
                        hold_take = 1'b1;
                    end else begin
                        hold_swap = 1'b1;
                    end
                end
`endif
            end
        end
    end

`ifdef TETROMINO_HOLD_EN
    assign gen_en = fill_en | pop_en | hold_take;
`else
    assign gen_en = fill_en | pop_en;
`endif
    assign load_en = game_start & ~game_end;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (load_en),
        .seed  (seed),
        .step  (gen_en),
        .value (lfsr_value)
    );

    // Queue, bag, FSM and hold state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            bag         <= BAG_FULL;
            fill_cnt    <= '0;
            pending     <= 1'b0;
            queue_valid <= 1'b0;
            for (int unsigned i = 0; i < QLEN; i++) q[i] <= PIECE_W'(PIECE_NONE);
`ifdef TETROMINO_HOLD_EN
            hold_q      <= PIECE_W'(PIECE_NONE);
            hold_used   <= 1'b0;
`endif
        end else if (game_end) begin
            state       <= ST_IDLE;
            pending     <= 1'b0;
            queue_valid <= 1'b0;
            for (int unsigned i = 0; i < QLEN; i++) q[i] <= PIECE_W'(PIECE_NONE);
`ifdef TETROMINO_HOLD_EN
            hold_q      <= PIECE_W'(PIECE_NONE);
`endif
        end else if (game_start) begin
            state       <= ST_FILL;
            bag         <= BAG_FULL;
            fill_cnt    <= '0;
            pending     <= 1'b0;
            queue_valid <= 1'b0;
            for (int unsigned i = 0; i < QLEN; i++) q[i] <= PIECE_W'(PIECE_NONE);
`ifdef TETROMINO_HOLD_EN
            hold_q      <= PIECE_W'(PIECE_NONE);
            hold_used   <= 1'b0;
`endif
        end else begin
            // Filling and popping both shift toward current and append at the tail.
            if (gen_en) begin
                for (int unsigned i = 0; i < QLEN - 1; i++) q[i] <= q[i+1];
                q[QLEN-1] <= gen_piece;
                bag       <= gen_bag;
            end
            case (state)
                ST_FILL: begin
                    if (new_tetromino) pending <= 1'b1;
                    if (fill_cnt == CNT_W'(PREVIEW_DEPTH)) begin
                        state       <= ST_READY;
                        queue_valid <= 1'b1;
                    end else begin
                        fill_cnt <= fill_cnt + 3'd1;
                    end
                end
                ST_READY: begin
                    if (pop_en) begin
                        pending <= 1'b0;
`ifdef TETROMINO_HOLD_EN
                        hold_used <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
`ifdef TETROMINO_HOLD_EN
            if (hold_take) begin
                hold_q    <= q[0];
                hold_used <= 1'b1;
            end
            if (hold_swap) begin
                hold_q    <= q[0];
                q[0]      <= hold_q;
                hold_used <= 1'b1;
            end
`endif
        end
    end

    assign current_piece = tile_type_t'(q[0]);

    for (genvar g = 0; g < PREVIEW_DEPTH; g++) begin : g_preview
        assign preview[PIECE_W*g +: PIECE_W] = q[g+1];
    end

`ifdef TETROMINO_HOLD_EN
    assign hold_piece = tile_type_t'(hold_q);
`else
    assign hold_piece = PIECE_NONE;
`endif

endmodule

// File: tb/tb_tetromino_bag_queue.sv
// Testbench for tetromino_bag_queue: randomised and directed stimulus checked
// against a queue/list-based reference model of the piece bag.
module tb_tetromino_bag_queue;
    import GamePkg::*;

    localparam int D  = 3;
    localparam int VW = 3*D + 7;
`ifdef TETROMINO_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             game_start = 1'b0;
    logic             game_end = 1'b0;
    logic [15:0]      seed = 16'h0;
    logic             new_tetromino = 1'b0;
    logic             hold_req = 1'b0;
    tile_type_t       current_piece;
    logic [3*D-1:0]   preview;
    logic             queue_valid;
    tile_type_t       hold_piece;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tetromino_bag_queue #(.PREVIEW_DEPTH(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .game_start    (game_start),
        .game_end      (game_end),
        .seed          (seed),
        .new_tetromino (new_tetromino),
        .hold_req      (hold_req),
        .current_piece (current_piece),
        .preview       (preview),
        .queue_valid   (queue_valid),
        .hold_piece    (hold_piece)
    );

    // Reference model: pieces as ints, bag as a sorted list of remaining pieces.
    int          mq[$];
    int          mbag[$];
    logic [15:0] mlfsr;
    int          mh;
    bit          mused, mvalid, mpend;
    int          mphase;   // 0 idle, 1 fill, 2 ready
    int          mfill;

    function automatic int model_gen();
        int k, p;
        mlfsr = (mlfsr >> 1) ^ (mlfsr[0] ? 16'hB400 : 16'h0000);
        k = int'(mlfsr[7:0]) % mbag.size();
        p = mbag[k];
        mbag.delete(k);
        if (mbag.size() == 0) mbag = '{0, 1, 2, 3, 4, 5, 6};
        return p;
    endfunction

    function automatic void model_pop();
        void'(mq.pop_front());
        mq.push_back(model_gen());
    endfunction

    function automatic void model_clear_q();
        mq.delete();
        for (int i = 0; i <= D; i++) mq.push_back(7);
    endfunction

    function automatic void model_reset();
        mlfsr = 16'hACE1;
        mbag = '{0, 1, 2, 3, 4, 5, 6};
        model_clear_q();
        mh = 7; mused = 0; mvalid = 0; mpend = 0; mphase = 0; mfill = 0;
    endfunction

    function automatic void model_update(bit gs, bit ge, bit nt, bit hr, logic [15:0] sd);
        int t;
        if (ge) begin
            mphase = 0; model_clear_q(); mh = 7; mvalid = 0; mpend = 0;
        end else if (gs) begin
            mlfsr = (sd == 16'h0) ? 16'hACE1 : sd;
            mbag = '{0, 1, 2, 3, 4, 5, 6};
            model_clear_q(); mh = 7; mused = 0; mvalid = 0; mpend = 0;
            mphase = 1; mfill = 0;
        end else if (mphase == 1) begin
            model_pop();
            if (nt) mpend = 1;
            mfill++;
            if (mfill == D + 1) begin mphase = 2; mvalid = 1; end
        end else if (mphase == 2) begin
            if (nt || mpend) begin
                model_pop(); mpend = 0; mused = 0;
            end else if (HOLD && hr && !mused) begin
                if (mh == 7) begin
                    mh = mq[0]; model_pop();
                end else begin
                    t = mq[0]; mq[0] = mh; mh = t;
                end
                mused = 1;
            end
        end
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [3*D-1:0] pv;
        for (int i = 0; i < D; i++) pv[3*i +: 3] = 3'(mq[i+1]);
        return {mvalid, 3'(mq[0]), pv, 3'(mh)};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {queue_valid, 3'(current_piece), preview, 3'(hold_piece)};
    endfunction

    // One clock: inputs applied for the coming edge, model advanced after it.
    task automatic cycle(input bit gs, input bit ge, input bit nt, input bit hr, input logic [15:0] sd);
        game_start = gs; game_end = ge; new_tetromino = nt; hold_req = hr; seed = sd;
        @(posedge clk); #1;
        model_update(gs, ge, nt, hr, sd);
        game_start = 0; game_end = 0; new_tetromino = 0; hold_req = 0; seed = 16'h0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!queue_valid && n < 12) begin
            cycle(0, 0, 0, 0, 16'h0);
            n++;
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        model_reset();
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++; $display("FAIL reset_hold: got %h want %h", obs_vec(), exp_vec());
        end
        checks++;
        if (queue_valid !== 1'b0 || 3'(current_piece) !== 3'd7 || 3'(hold_piece) !== 3'd7) begin
            failures++; $display("FAIL reset_values: valid=%b cur=%0d hold=%0d want 0/7/7",
                                 queue_valid, current_piece, hold_piece);
        end
        rst = 1'b0;
        cycle(0, 0, 0, 0, 16'h0);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++; $display("FAIL reset_release: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_fill_and_perm();
        int n;
        int sq[$];
        logic [6:0] m0, m1;
        cycle(1, 0, 0, 0, 16'h0001);
        n = 0;
        while (!queue_valid && n < 12) begin
            cycle(0, 0, 0, 0, 16'h0);
            n++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++; $display("FAIL fill_cycle%0d: got %h want %h", n, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (n !== D + 1) begin
            failures++; $display("FAIL valid_latency: got %0d cycles want %0d", n, D + 1);
        end
        sq.push_back(int'(current_piece));
        for (int i = 0; i < 14; i++) begin
            cycle(0, 0, 1, 0, 16'h0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++; $display("FAIL pop%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            sq.push_back(int'(current_piece));
            cycle(0, 0, 0, 0, 16'h0);
        end
        m0 = '0; m1 = '0;
        for (int i = 0; i < 7; i++) begin
            if (sq[i] < 7) m0[sq[i]] = 1'b1;
            if (sq[i+7] < 7) m1[sq[i+7]] = 1'b1;
        end
        checks++;
        if (m0 !== 7'h7F) begin
            failures++; $display("FAIL perm_first: got %b want 1111111", m0);
        end
        checks++;
        if (m1 !== 7'h7F) begin
            failures++; $display("FAIL perm_second: got %b want 1111111", m1);
        end
    endtask

    task automatic test_seed_zero();
        int n;
        logic [15:0] seeds [2];
        seeds[0] = 16'h0000; seeds[1] = 16'hACE1;
        for (int s = 0; s < 2; s++) begin
            cycle(1, 0, 0, 0, seeds[s]);
            wait_ready(n);
            checks++;
            if (n !== D + 1) begin
                failures++; $display("FAIL seed%0d_latency: got %0d want %0d", s, n, D + 1);
            end
            for (int i = 0; i < 9; i++) begin
                cycle(0, 0, 1, 0, 16'h0);
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    failures++; $display("FAIL seed%0d_pop%0d: got %h want %h", s, i, obs_vec(), exp_vec());
                end
            end
        end
    endtask

    task automatic test_pending();
        int n;
        cycle(1, 0, 0, 0, 16'($urandom));
        cycle(0, 0, 1, 0, 16'h0);
        cycle(0, 0, 1, 0, 16'h0);
        wait_ready(n);
        checks++;
        if (n !== D - 1) begin
            failures++; $display("FAIL pending_latency: got %0d want %0d", n, D - 1);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++; $display("FAIL pending_step%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            cycle(0, 0, 0, 0, 16'h0);
        end
    endtask

`ifdef TETROMINO_HOLD_EN
    task automatic test_hold();
        int n, oc, op, oh;
        cycle(1, 0, 0, 0, 16'h1234);
        wait_ready(n);
        checks++;
        if (n !== D + 1) begin
            failures++; $display("FAIL hold_latency: got %0d want %0d", n, D + 1);
        end
        oc = mq[0]; op = mq[1];
        cycle(0, 0, 0, 1, 16'h0);
        checks++;
        if (int'(hold_piece) !== oc || int'(current_piece) !== op) begin
            failures++; $display("FAIL hold_take: hold=%0d cur=%0d want %0d/%0d", hold_piece, current_piece, oc, op);
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++; $display("FAIL hold_take_vec: got %h want %h", obs_vec(), exp_vec());
        end
        cycle(0, 0, 0, 1, 16'h0);
        checks++;
        if (int'(hold_piece) !== oc || int'(current_piece) !== op) begin
            failures++; $display("FAIL hold_second: hold=%0d cur=%0d want %0d/%0d", hold_piece, current_piece, oc, op);
        end
        cycle(0, 0, 1, 0, 16'h0);
        oc = mq[0]; oh = mh;
        cycle(0, 0, 0, 1, 16'h0);
        checks++;
        if (int'(hold_piece) !== oc || int'(current_piece) !== oh) begin
            failures++; $display("FAIL hold_swap: hold=%0d cur=%0d want %0d/%0d", hold_piece, current_piece, oc, oh);
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++; $display("FAIL hold_swap_vec: got %h want %h", obs_vec(), exp_vec());
        end
        cycle(0, 0, 1, 0, 16'h0);
        oh = mh;
        cycle(0, 0, 1, 1, 16'h0);
        checks++;
        if (int'(hold_piece) !== oh || obs_vec() !== exp_vec()) begin
            failures++; $display("FAIL pop_with_hold: got %h want %h", obs_vec(), exp_vec());
        end
    endtask
`else
    task automatic test_hold_disabled();
        int n;
        cycle(1, 0, 0, 0, 16'h1234);
        wait_ready(n);
        checks++;
        if (n !== D + 1) begin
            failures++; $display("FAIL nohold_latency: got %0d want %0d", n, D + 1);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 1, 16'h0);
            checks++;
            if (obs_vec() !== exp_vec() || 3'(hold_piece) !== 3'd7) begin
                failures++; $display("FAIL nohold_req%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        cycle(0, 0, 1, 1, 16'h0);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++; $display("FAIL nohold_pop: got %h want %h", obs_vec(), exp_vec());
        end
    endtask
`endif

    task automatic test_reset_mid_fill();
        cycle(1, 0, 0, 0, 16'hBEEF);
        cycle(0, 0, 1, 0, 16'h0);
        rst = 1'b1;
        #2;
        model_reset();
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++; $display("FAIL midfill_reset: got %h want %h", obs_vec(), exp_vec());
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 0, 0, 16'h0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++; $display("FAIL midfill_after%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_game_end();
        int n;
        cycle(1, 0, 0, 0, 16'h0777);
        wait_ready(n);
        cycle(0, 0, 1, 0, 16'h0);
        cycle(0, 0, 0, 1, 16'h0);
        cycle(0, 1, 0, 0, 16'h0);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++; $display("FAIL game_end: got %h want %h", obs_vec(), exp_vec());
        end
        cycle(0, 0, 1, 1, 16'h0);
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++; $display("FAIL idle_ignore: got %h want %h", obs_vec(), exp_vec());
        end
        cycle(1, 0, 0, 0, 16'h4321);
        cycle(0, 0, 0, 0, 16'h0);
        cycle(1, 1, 0, 0, 16'h0055);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++; $display("FAIL end_priority%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            cycle(0, 0, 0, 0, 16'h0);
        end
    endtask

    task automatic test_random();
        bit gs, nt, hr;
        cycle(1, 0, 0, 0, 16'($urandom));
        for (int i = 0; i < 400; i++) begin
            gs = ($urandom_range(0, 99) == 0);
            nt = ($urandom_range(0, 9) < 4);
            hr = ($urandom_range(0, 9) < 3);
            cycle(gs, 0, nt, hr, 16'($urandom));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++; $display("FAIL random%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_and_perm();
        test_seed_zero();
        test_pending();
`ifdef TETROMINO_HOLD_EN
        test_hold();
`else
        test_hold_disabled();
`endif
        test_reset_mid_fill();
        test_game_end();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
